// File: rtl/sm_result_display.sv
// Result display for the 3-bit sign-magnitude adder: captures a result on load and
// scans it onto a two-digit active-low seven-segment display with sign/zero LEDs.
module sm_result_display #(
   parameter int REFRESH_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] result,
   input  logic       zeroflag,
   input  logic       load,
   input  logic       clear,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       neg_led,
   output logic       zero_led,
   output logic       showing
);

   localparam int            CW       = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t        state, state_next;
   logic          capture;
   logic [CW-1:0] cnt;
   logic          digit_sel;
   logic [2:0]    mag;
   logic          sgn;
   logic          zcap;
   logic [6:0]    seg_next;
   logic [1:0]    an_next;
   logic          neg_next;
   logic          zero_next;
   logic          unused_result_bit;

   assign unused_result_bit = result[3];

   function automatic logic [6:0] decode(input logic [2:0] m);
      case (m)
         3'd0:    decode = 7'h40;
         3'd1:    decode = 7'h79;
         3'd2:    decode = 7'h24;
         3'd3:    decode = 7'h30;
         3'd4:    decode = 7'h19;
         3'd5:    decode = 7'h12;
         3'd6:    decode = 7'h02;
         default: decode = 7'h78;
      endcase
   endfunction

   // Clear outranks load in both states, and a cleared cycle captures nothing.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         BLANK: begin
            if (!clear && load) begin
               state_next = SHOW;
               capture    = 1'b1;
            end
         end
         SHOW: begin
            if (clear) begin
               state_next = BLANK;
            end else if (load) begin
               capture = 1'b1;
            end
         end
         default: state_next = BLANK;
      endcase
   end

   always_comb begin
      seg_next  = 7'h7F;
      an_next   = 2'b11;
      neg_next  = 1'b0;
      zero_next = 1'b0;
      if (state == SHOW) begin
         neg_next  = sgn;
         zero_next = zcap;
         if (!digit_sel) begin
            an_next  = 2'b10;
            seg_next = decode(mag);
         end else begin
            an_next  = 2'b01;
            seg_next = sgn ? 7'h3F : 7'h7F;
         end
      end
   end

   // Outputs lag the state and captured registers by one clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= BLANK;
         cnt       <= '0;
         digit_sel <= 1'b0;
         mag       <= 3'd0;
         sgn       <= 1'b0;
         zcap      <= 1'b0;
         seg       <= 7'h7F;
         an        <= 2'b11;
         neg_led   <= 1'b0;
         zero_led  <= 1'b0;
      end else begin
         state <= state_next;
         if (cnt == CNT_LAST) begin
            cnt       <= '0;
            digit_sel <= ~digit_sel;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (capture) begin
            mag  <= result[2:0];
            sgn  <= result[4] & (result[2:0] != 3'd0);
            zcap <= zeroflag;
         end
         seg      <= seg_next;
         an       <= an_next;
         neg_led  <= neg_next;
         zero_led <= zero_next;
      end
   end

   assign showing = (state == SHOW);

endmodule

// File: tb/tb_sm_result_display.sv
// Directed table-driven bench for sm_result_display with REFRESH_DIV = 4.
module tb_sm_result_display;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] result;
   logic       zeroflag;
   logic       load;
   logic       clear;
   logic [6:0] seg;
   logic [1:0] an;
   logic       neg_led;
   logic       zero_led;
   logic       showing;

   int compared   = 0;
   int mismatched = 0;

   sm_result_display #(.REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .result(result), .zeroflag(zeroflag),
      .load(load), .clear(clear), .seg(seg), .an(an),
      .neg_led(neg_led), .zero_led(zero_led), .showing(showing)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       load;
      logic       clear;
      logic [4:0] result;
      logic       zf;
      logic [6:0] seg;
      logic [1:0] an;
      logic       neg;
      logic       zero;
      logic       show;
   } vec_t;

   vec_t vecs[30];

   function automatic vec_t mk(input logic l, input logic c, input logic [4:0] r, input logic z,
                               input logic [6:0] s, input logic [1:0] a, input logic n,
                               input logic zo, input logic sh);
      vec_t v;
      v.load = l; v.clear = c; v.result = r; v.zf = z;
      v.seg = s; v.an = a; v.neg = n; v.zero = zo; v.show = sh;
      return v;
   endfunction

   task automatic applyStimulus(input logic r, input logic l, input logic c,
                                input logic [4:0] res, input logic z);
      rst = r; load = l; clear = c; result = res; zeroflag = z;
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input string field, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("[TB] FAIL %s %s: got %h, expected %h", name, field, got, want);
      end
   endtask

   task automatic checkOutput(input string name, input logic [6:0] s, input logic [1:0] a,
                              input logic n, input logic zo, input logic sh);
      cmp(name, "seg", int'(seg), int'(s));
      cmp(name, "an", int'(an), int'(a));
      cmp(name, "neg_led", int'(neg_led), int'(n));
      cmp(name, "zero_led", int'(zero_led), int'(zo));
      cmp(name, "showing", int'(showing), int'(sh));
   endtask

   initial begin
      // Edge n after reset release: counter = n mod 4, digit_sel = (n/4) mod 2,
      // and outputs at edge n reflect the registers as they stood after edge n-1.
      vecs[0]  = mk(1, 0, 5'b10011, 0, 7'h7F, 2'b11, 0, 0, 1);
      vecs[1]  = mk(0, 0, 5'b11101, 1, 7'h30, 2'b10, 1, 0, 1);
      vecs[2]  = mk(0, 0, 5'b11101, 1, 7'h30, 2'b10, 1, 0, 1);
      vecs[3]  = mk(0, 0, 5'b11101, 1, 7'h30, 2'b10, 1, 0, 1);
      vecs[4]  = mk(0, 0, 5'b11101, 1, 7'h3F, 2'b01, 1, 0, 1);
      vecs[5]  = mk(0, 0, 5'b11101, 1, 7'h3F, 2'b01, 1, 0, 1);
      vecs[6]  = mk(0, 0, 5'b11101, 1, 7'h3F, 2'b01, 1, 0, 1);
      vecs[7]  = mk(0, 0, 5'b11101, 1, 7'h3F, 2'b01, 1, 0, 1);
      vecs[8]  = mk(0, 0, 5'b11101, 1, 7'h30, 2'b10, 1, 0, 1);
      vecs[9]  = mk(1, 0, 5'b00110, 0, 7'h30, 2'b10, 1, 0, 1);
      vecs[10] = mk(0, 0, 5'b11101, 1, 7'h02, 2'b10, 0, 0, 1);
      vecs[11] = mk(0, 0, 5'b11101, 1, 7'h02, 2'b10, 0, 0, 1);
      vecs[12] = mk(0, 0, 5'b11101, 1, 7'h7F, 2'b01, 0, 0, 1);
      vecs[13] = mk(0, 0, 5'b11101, 1, 7'h7F, 2'b01, 0, 0, 1);
      vecs[14] = mk(1, 0, 5'b10000, 1, 7'h7F, 2'b01, 0, 0, 1);
      vecs[15] = mk(0, 0, 5'b11101, 0, 7'h7F, 2'b01, 0, 1, 1);
      vecs[16] = mk(0, 0, 5'b11101, 0, 7'h40, 2'b10, 0, 1, 1);
      vecs[17] = mk(0, 0, 5'b11101, 0, 7'h40, 2'b10, 0, 1, 1);
      vecs[18] = mk(1, 1, 5'b00001, 0, 7'h40, 2'b10, 0, 1, 0);
      vecs[19] = mk(0, 0, 5'b11101, 1, 7'h7F, 2'b11, 0, 0, 0);
      vecs[20] = mk(1, 0, 5'b00000, 0, 7'h7F, 2'b11, 0, 0, 1);
      vecs[21] = mk(0, 0, 5'b11101, 1, 7'h7F, 2'b01, 0, 0, 1);
      vecs[22] = mk(0, 0, 5'b11101, 1, 7'h7F, 2'b01, 0, 0, 1);
      vecs[23] = mk(0, 0, 5'b11101, 1, 7'h7F, 2'b01, 0, 0, 1);
      vecs[24] = mk(0, 0, 5'b11101, 1, 7'h40, 2'b10, 0, 0, 1);
      vecs[25] = mk(0, 0, 5'b11101, 1, 7'h40, 2'b10, 0, 0, 1);
      vecs[26] = mk(0, 0, 5'b11101, 1, 7'h40, 2'b10, 0, 0, 1);
      vecs[27] = mk(0, 0, 5'b11101, 1, 7'h40, 2'b10, 0, 0, 1);
      vecs[28] = mk(0, 0, 5'b11101, 1, 7'h7F, 2'b01, 0, 0, 1);
      vecs[29] = mk(0, 0, 5'b11101, 1, 7'h7F, 2'b01, 0, 0, 1);

      // Reset held for several edges with load/clear active must keep everything idle.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, i[0], 5'b10011, 1'b1);
         checkOutput($sformatf("reset%0d", i), 7'h7F, 2'b11, 1'b0, 1'b0, 1'b0);
      end

      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b0, vecs[i].load, vecs[i].clear, vecs[i].result, vecs[i].zf);
         checkOutput($sformatf("vec%0d", i + 1), vecs[i].seg, vecs[i].an,
                     vecs[i].neg, vecs[i].zero, vecs[i].show);
      end

      // Counter is 2 and digit_sel is 1 here; reset with load asserted must win.
      applyStimulus(1'b1, 1'b1, 1'b0, 5'b10011, 1'b0);
      checkOutput("midscan_reset", 7'h7F, 2'b11, 1'b0, 1'b0, 1'b0);

      // Scan must restart at counter 0, digit 0, exactly as after the first reset.
      applyStimulus(1'b0, 1'b1, 1'b0, 5'b10011, 1'b0);
      checkOutput("restart1", 7'h7F, 2'b11, 1'b0, 1'b0, 1'b1);
      for (int i = 2; i <= 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
         checkOutput($sformatf("restart%0d", i), 7'h30, 2'b10, 1'b1, 1'b0, 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
      checkOutput("restart5", 7'h3F, 2'b01, 1'b1, 1'b0, 1'b1);

      // Magnitude 7 is decoded like any other value.
      applyStimulus(1'b0, 1'b1, 1'b0, 5'b10111, 1'b0);
      checkOutput("mag7_load", 7'h3F, 2'b01, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
      checkOutput("mag7_sign1", 7'h3F, 2'b01, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
      checkOutput("mag7_sign2", 7'h3F, 2'b01, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
      checkOutput("mag7_digit", 7'h78, 2'b10, 1'b1, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sm_result_display.md
Name: sm_result_display

Overview:
Downstream consumer of the 3-bit sign-magnitude add/subtract stage. Latches the 5-bit result and zero flag on a load strobe. Drives a two-digit, time-multiplexed, active-low seven-segment display: digit1 shows the sign, digit0 shows the magnitude. Also drives sign and zero status LEDs, and holds the display between operations.

Parameters:
REFRESH_DIV, 4, clock cycles each digit stays enabled before the scan toggles to the other digit; legal range is 2 and above.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
result  input  5  adder output: bit4 is sign (1 = negative), bits 2:0 are magnitude, bit3 is ignored
zeroflag  input  1  adder zero flag
load  input  1  single-cycle strobe that captures result and zeroflag
clear  input  1  single-cycle strobe that blanks the display
seg  output  7  segments gfedcba, active-low, registered
an  output  2  digit enables, active-low, registered; an[0] is the magnitude digit, an[1] is the sign digit
neg_led  output  1  captured sign after zero normalisation, registered
zero_led  output  1  captured zeroflag, registered
showing  output  1  high while the FSM is in SHOW

Behaviour:
- Single clock domain. Reset is synchronous and active-high: it is sampled only on the rising edge of clk, and rst = 1 forces the reset state.
- Reset values:
  - state = BLANK, refresh counter = 0, digit_sel = 0.
  - captured magnitude = 0, captured sign = 0, captured zero = 0.
  - seg = 7'h7F, an = 2'b11, neg_led = 0, zero_led = 0, showing = 0.
- Reset has priority over load and clear. Reset asserted mid-scan aborts the scan and returns every register to its reset value on that edge.
- FSM has two states:
  - BLANK: load = 1 moves to SHOW. Otherwise stay in BLANK.
  - SHOW: clear = 1 moves to BLANK. Otherwise load = 1 stays in SHOW and recaptures.
  - load and clear asserted together: clear wins. The state goes to BLANK and nothing is captured.
- Capture rules, applied on the edge where load is accepted:
  - mag <= result[2:0]; zcap <= zeroflag.
  - sgn <= result[4] AND (result[2:0] != 0). Negative zero is normalised to positive.
  - clear does not reset the captured registers. It only blanks the display and LEDs.
- Refresh counter:
  - Free-runs in both states and counts 0 to REFRESH_DIV-1, then wraps to 0.
  - digit_sel toggles on the wrap edge.
  - load and clear do not disturb the counter or digit_sel.
- Outputs are registered with a one-cycle latency from the state and captured registers. A load accepted at edge k is reflected on seg/an/LEDs at edge k+1.
  - In BLANK: seg = 7'h7F, an = 2'b11, neg_led = 0, zero_led = 0.
  - In SHOW with digit_sel = 0: an = 2'b10 and seg = decode(mag).
  - In SHOW with digit_sel = 1: an = 2'b01. seg = 7'h3F (minus sign) if sgn = 1, else 7'h7F (blank).
  - In SHOW: neg_led = sgn and zero_led = zcap.
- decode(mag), gfedcba active-low: 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78 (hex).
- Valid adder magnitudes are 0 to 6. The value 7 is still decoded and is not treated as an error.
- An consistency check between zeroflag and the magnitude is not performed. The flag is displayed exactly as captured.
- Exactly one bit of an is low at any time in SHOW; no cycle has both digits enabled.

Test Plan:
1. Reset with REFRESH_DIV = 4 -> seg = 7F, an = 11, neg_led = 0, zero_led = 0, showing = 0; counter held at 0 while rst = 1.
2. load with result = 5'b10011, zeroflag = 0 -> showing = 1 the next cycle, neg_led = 1. The display alternates every 4 cycles between an = 10 / seg = 30 and an = 01 / seg = 3F.
3. load with result = 5'b00110 -> digit0 shows seg = 02, digit1 shows seg = 7F, neg_led = 0.
4. load with result = 5'b10000, zeroflag = 1 -> digit0 shows seg = 40, digit1 shows seg = 7F (negative zero normalised), neg_led = 0, zero_led = 1.
5. In SHOW, assert load (result = 5'b00001) and clear in the same cycle -> the next cycle shows an = 11, seg = 7F, showing = 0. A subsequent load with result = 5'b00000 shows mag 0, proving the 00001 was never captured.
6. Assert rst mid-scan (counter = 2, digit_sel = 1) while load = 1 -> reset values on that edge. After rst is released, the counter restarts from 0 with digit_sel = 0.
